// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_timeout_cnt.sv
// WAIT-cycle watchdog: clears when an access starts and counts WAIT cycles without ack.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Fires during the last allowed WAIT cycle so the FSM leaves after exactly TIMEOUT cycles.
  assign expired = (cnt_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage handshake controller: IDLE -> WAIT -> DONE per access, stalls the pipeline meanwhile.
// Optional WAIT timeout with sticky err_o is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mem_stage_ctrl: TIMEOUT must be at least 1");
  end

  mem_state_t        state_reg, state_next;
  logic              req_any;
  logic              start_access;
  logic              timeout_hit;
  logic [DATA_W-1:0] addr_reg, wdata_reg, rdata_reg;
  logic              we_reg;

  assign req_any      = MemRead_i | MemWrite_i;
  assign start_access = (state_reg == IDLE) && req_any;

`ifdef MEM_TIMEOUT_EN
  logic err_reg;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (start_access),
    .en      ((state_reg == WAIT) && !mem_ack_i),
    .expired (timeout_hit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_reg <= 1'b0;
    end else if ((state_reg == WAIT) && !mem_ack_i && timeout_hit) begin
      err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A request seen in DONE is the next instruction, picked up once back in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_any) state_next = WAIT;
      WAIT:    if (mem_ack_i || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o = (state_reg == WAIT);
    stall_o   = start_access || (state_reg == WAIT);
  end

  // Write wins when both request lines are high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      rdata_reg <= '0;
    end else begin
      if (start_access) begin
        addr_reg  <= addr_i;
        wdata_reg <= wdata_i;
        we_reg    <= MemWrite_i;
      end
      if ((state_reg == WAIT) && mem_ack_i && !we_reg) begin
        rdata_reg <= mem_rdata_i;
      end
    end
  end

  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign mem_we_o    = we_reg;
  assign rdata_o     = rdata_reg;

endmodule
